ifetch_queue: RTL and testbench

Parametrised instruction-fetch unit for the single-issue core. It owns the PC, issues word fetches to instruction memory over a request/grant/response-valid interface, and buffers returned words in a QDEPTH-entry queue. It presents the buffered words to decode with a valid/ready handshake. A redirect flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifetch_queue_if.sv | 31 +++
 rtl/ifetch_queue.sv | 197 +++++++++++++++++++
 tb/tb_ifetch_queue.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the instruction-memory request/response bus and the
// decode-side valid/ready handshake of the fetch unit.
// master = fetch unit (drives requests, presents instructions),
// slave  = memory + decode side.
interface ifetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch unit. Owns the PC, issues word fetches to
// instruction memory, tags each request with its PC, and buffers returned
// words in a QDEPTH-entry queue presented to decode by valid/ready.
// A redirect reloads the PC, flushes the queue and tag FIFO, and turns every
// outstanding request into a response to be discarded.
// Optional feature macro IFETCH_MISALIGN_CHK_EN: when defined, a redirect to a
// non-word-aligned target sets a sticky misalign flag and halts fetch until
// the next aligned redirect; when undefined, the low two target bits are
// cleared and misalign is tied low.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign,
  ifetch_queue_if.master  bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] new_pc;
  logic            halt;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credits;

  logic [XLEN-1:0] tag_mem [QDEPTH];
  logic [PW-1:0]   tag_wr;
  logic [PW-1:0]   tag_rd;

  logic [31:0]     q_data [QDEPTH];
  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [QDEPTH-1:0] q_valid;
  logic [CW-1:0]   q_cnt;

  logic [31:0]     n_data [QDEPTH];
  logic [XLEN-1:0] n_pc   [QDEPTH];
  logic [QDEPTH-1:0] n_valid;
  logic [CW-1:0]   n_cnt;
  logic [CW-1:0]   widx;

  logic fire;
  logic pop;
  logic take;
  logic push;

  // A returned word is consumed from the tag FIFO only when it is not owed to
  // an earlier redirect; it reaches the queue only if no redirect is flushing.
  assign fire = bus.imem_req && bus.imem_gnt;
  assign pop  = q_valid[0] && bus.inst_ready;
  assign take = bus.imem_rvalid && (drop_cnt == '0);
  assign push = take && !redirect;

  // Every granted-but-unreturned request (dropped or not) plus every stored
  // word holds a slot; a head leaving this cycle frees its slot at once so
  // the pipeline can stream one word per cycle. No path from imem_gnt.
  assign credits  = {1'b0, outstanding} + {1'b0, q_cnt};
  assign bus.imem_req  = rst && !halt && ((credits < (CW+1)'(QDEPTH)) || pop);
  assign bus.imem_addr = pc;

  assign bus.inst_valid = q_valid[0];
  assign bus.inst       = q_data[0];
  assign bus.inst_pc    = q_pc[0];

  assign outstanding_next = outstanding + CW'(fire) - CW'(bus.imem_rvalid);

`ifdef IFETCH_MISALIGN_CHK_EN
  assign new_pc = redirect_pc;
  assign halt   = misalign;

  // Sticky misaligned-target flag; only a later aligned redirect clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign <= 1'b0;
    end else if (redirect) begin
      misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign new_pc   = redirect_pc & ~(XLEN'(3));
  assign halt     = 1'b0;
  assign misalign = 1'b0;
`endif

  // PC: redirect target wins, otherwise step one word per granted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= new_pc;
    end else if (fire) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Outstanding requests and the number of upcoming responses to discard;
  // on redirect everything still in flight (including this cycle's grant)
  // becomes a drop, which also covers an earlier, still-draining redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        drop_cnt <= outstanding_next;
      end else if (bus.imem_rvalid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Tag FIFO pointers: push the requested PC on grant, pop on a kept response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else if (redirect) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (fire) begin
        tag_wr <= tag_wr + PW'(1);
      end
      if (take) begin
        tag_rd <= tag_rd + PW'(1);
      end
    end
  end

  // Tag FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (fire && !redirect) begin
      tag_mem[tag_wr] <= pc;
    end
  end

  // Next queue image: entry 0 is always the head, so a pop shifts down and a
  // push lands just past the last valid entry after any shift.
  always_comb begin
    n_data  = q_data;
    n_pc    = q_pc;
    n_valid = q_valid;
    n_cnt   = q_cnt;
    widx    = q_cnt;
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        n_data[i]  = q_data[i+1];
        n_pc[i]    = q_pc[i+1];
        n_valid[i] = q_valid[i+1];
      end
      n_valid[QDEPTH-1] = 1'b0;
      widx  = q_cnt - CW'(1);
      n_cnt = q_cnt - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (CW'(i) == widx) begin
          n_data[i]  = bus.imem_rdata;
          n_pc[i]    = tag_mem[tag_rd];
          n_valid[i] = 1'b1;
        end
      end
      n_cnt = n_cnt + CW'(1);
    end
    if (redirect) begin
      n_valid = '0;
      n_cnt   = '0;
    end
  end

  // Queue registers; reset clears data too so the head outputs read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
      q_valid <= '0;
      q_cnt   <= '0;
    end else begin
      q_data  <= n_data;
      q_pc    <= n_pc;
      q_valid <= n_valid;
      q_cnt   <= n_cnt;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue. A behavioural
// instruction memory with fixed latency answers grants; every kept response
// is pushed to a scoreboard and compared when decode pops it. A per-cycle
// vector table covers start-up, stall and redirect timing, followed by
// hand-written corner sequences and a randomised phase.
module tb_ifetch_queue;

  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign;

  ifetch_queue_if #(.XLEN(XLEN)) bus ();

  ifetch_queue #(.XLEN(XLEN), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .misalign   (misalign),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          due;
    bit          dead;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] popped[$];
  pend_t       rsp;
  bit          rsp_valid;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          grants = 0;
  bit          gnt_en = 1'b1;
  logic [31:0] exp_pc = RESET_PC;
  bit          exp_mis = 1'b0;
  vec_t        tbl[13];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive this cycle's inputs at the falling edge, answer due responses,
  // then grant combinationally from the settled request.
  task automatic applyStimulus(input bit rdy, input bit rd, input logic [31:0] rpc);
    bus.inst_ready   = rdy;
    redirect         = rd;
    redirect_pc      = rpc;
    rsp_valid        = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp             = pend.pop_front();
      rsp_valid       = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memData(rsp.addr);
    end
    #1;
    bus.imem_gnt = bus.imem_req && gnt_en;
    #1;
  endtask

  task automatic checkOutput(input int k, input vec_t v);
    checkValue($sformatf("tbl%0d_req", k), 32'(bus.imem_req), 32'(v.e_req));
    checkValue($sformatf("tbl%0d_addr", k), bus.imem_addr, v.e_addr);
    checkValue($sformatf("tbl%0d_valid", k), 32'(bus.inst_valid), 32'(v.e_valid));
    if (v.e_valid) checkValue($sformatf("tbl%0d_pc", k), bus.inst_pc, v.e_pc);
  endtask

  // Scoreboard compare, then model update, then advance one clock.
  task automatic stepCycle();
    bit fire;
    checkValue("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0 && bus.inst_valid) begin
      checkValue("inst_pc", bus.inst_pc, exp_q[0].pc);
      checkValue("inst", bus.inst, exp_q[0].data);
    end
    checkValue("imem_addr", bus.imem_addr, exp_pc);
    checkValue("misalign", 32'(misalign), 32'(exp_mis));
    if (exp_mis) checkValue("halt_req", 32'(bus.imem_req), 32'h0);
    checkValue("credit_bound", 32'(pend.size() + int'(rsp_valid) + exp_q.size() <= QDEPTH), 32'h1);
    fire = bus.imem_req && bus.imem_gnt;
    if (fire) grants++;
    if (bus.inst_valid && bus.inst_ready && !redirect && exp_q.size() > 0) begin
      popped.push_back(exp_q[0].pc);
      void'(exp_q.pop_front());
    end
    if (rsp_valid && !rsp.dead && !redirect)
      exp_q.push_back('{pc: rsp.pc, data: memData(rsp.pc)});
    if (fire)
      pend.push_back('{addr: bus.imem_addr, pc: exp_pc, due: cyc + lat, dead: redirect});
    if (redirect) begin
      foreach (pend[i]) pend[i].dead = 1'b1;
      exp_q.delete();
`ifdef IFETCH_MISALIGN_CHK_EN
      exp_mis = (redirect_pc[1:0] != 2'b00);
      exp_pc  = redirect_pc;
`else
      exp_mis = 1'b0;
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (fire) begin
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asserts reset, checks the asynchronous reset values, releases at a
  // falling edge so the next cycle is the first one out of reset.
  task automatic doReset();
    rst             = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.inst_ready  = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    rsp_valid       = 1'b0;
    pend.delete();
    exp_q.delete();
    exp_pc  = RESET_PC;
    exp_mis = 1'b0;
    #1;
    checkValue("rst_req", 32'(bus.imem_req), 32'h0);
    checkValue("rst_addr", bus.imem_addr, RESET_PC);
    checkValue("rst_valid", 32'(bus.inst_valid), 32'h0);
    checkValue("rst_inst", bus.inst, 32'h0);
    checkValue("rst_inst_pc", bus.inst_pc, 32'h0);
    checkValue("rst_misalign", 32'(misalign), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitFirstValid(input string name, input logic [31:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (bus.inst_valid) begin
        checkValue(name, bus.inst_pc, want);
        found = 1'b1;
      end
      stepCycle();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no inst_valid within 20 cycles, expected pc %h", name, want);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.inst_ready  = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;

    // rdy rd rpc | req addr valid pc   (1-cycle memory, always granted)
    tbl[0]  = '{1, 0, 32'h0,   1, 32'h000, 0, 32'h000};
    tbl[1]  = '{1, 0, 32'h0,   1, 32'h004, 0, 32'h000};
    tbl[2]  = '{1, 0, 32'h0,   1, 32'h008, 1, 32'h000};
    tbl[3]  = '{1, 0, 32'h0,   1, 32'h00C, 1, 32'h004};
    tbl[4]  = '{0, 0, 32'h0,   0, 32'h010, 1, 32'h008};
    tbl[5]  = '{0, 0, 32'h0,   0, 32'h010, 1, 32'h008};
    tbl[6]  = '{1, 0, 32'h0,   1, 32'h010, 1, 32'h008};
    tbl[7]  = '{1, 0, 32'h0,   1, 32'h014, 1, 32'h00C};
    tbl[8]  = '{1, 1, 32'h100, 1, 32'h018, 1, 32'h010};
    tbl[9]  = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h000};
    tbl[10] = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h000};
    tbl[11] = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    tbl[12] = '{1, 0, 32'h0,   1, 32'h10C, 1, 32'h104};

    @(negedge clk);
    $display("[TB] vector table: start-up, stall, redirect with grant and rvalid");
    lat = 1;
    gnt_en = 1'b1;
    doReset();
    for (int k = 0; k < 13; k++) begin
      applyStimulus(tbl[k].rdy, tbl[k].rd, tbl[k].rpc);
      checkOutput(k, tbl[k]);
      stepCycle();
    end

    $display("[TB] sustained streaming with decode always ready");
    doReset();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkValue("stream_req", 32'(bus.imem_req), 32'h1);
      if (k >= 2) checkValue("stream_valid", 32'(bus.inst_valid), 32'h1);
      stepCycle();
    end

    $display("[TB] decode stalled for 10 cycles");
    doReset();
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (k >= 2) checkValue("stall_req", 32'(bus.imem_req), 32'h0);
      stepCycle();
    end
    checkValue("stall_grants", 32'(grants), 32'd2);
    popped.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      stepCycle();
    end
    checkValue("stall_delivered", 32'(popped.size() >= 2), 32'h1);
    if (popped.size() >= 2) begin
      checkValue("stall_first_pc", popped[0], 32'h0);
      checkValue("stall_second_pc", popped[1], 32'h4);
    end

    $display("[TB] 3-cycle memory, redirect with two requests in flight");
    doReset();
    lat = 3;
    applyStimulus(1'b1, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkValue("lat3_req_full", 32'(bus.imem_req), 32'h0);
    stepCycle();
    waitFirstValid("lat3_first_pc", 32'h100);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      stepCycle();
    end

    $display("[TB] misaligned redirect target");
    doReset();
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b1, 32'h102);
    stepCycle();
`ifdef IFETCH_MISALIGN_CHK_EN
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkValue("mis_flag", 32'(misalign), 32'h1);
      checkValue("mis_halt_req", 32'(bus.imem_req), 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b1, 32'h200);
    stepCycle();
    applyStimulus(1'b1, 1'b0, '0);
    checkValue("mis_clear", 32'(misalign), 32'h0);
    checkValue("mis_resume_addr", bus.imem_addr, 32'h200);
    checkValue("mis_resume_req", 32'(bus.imem_req), 32'h1);
    stepCycle();
    waitFirstValid("mis_resume_pc", 32'h200);
`else
    applyStimulus(1'b1, 1'b0, '0);
    checkValue("align_addr", bus.imem_addr, 32'h100);
    checkValue("align_flag", 32'(misalign), 32'h0);
    stepCycle();
    waitFirstValid("align_first_pc", 32'h100);
`endif

    $display("[TB] reset asserted mid-stream with queue full");
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkValue("full_valid", 32'(bus.inst_valid), 32'h1);
    checkValue("full_req", 32'(bus.imem_req), 32'h0);
    doReset();
    applyStimulus(1'b1, 1'b0, '0);
    checkValue("restart_addr", bus.imem_addr, RESET_PC);
    checkValue("restart_req", 32'(bus.imem_req), 32'h1);
    stepCycle();
    waitFirstValid("restart_first_pc", RESET_PC);

    $display("[TB] randomised grants, decode stalls and redirects");
    doReset();
    lat = 2;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] rpc;
      gnt_en = ($urandom_range(0, 3) != 0);
      rpc = 32'h1000 + (32'($urandom_range(0, 63)) << 2)
            + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
      stepCycle();
    end
    gnt_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
